// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct encodings, ALU control codes and ID-stage types.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR  = 6'h25, F_XOR  = 6'h26, F_SLT = 6'h2A;
  localparam logic [3:0] ALU_SLL = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB = 4'b0010, ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101, ALU_XOR = 4'b0110, ALU_LUI = 4'b0111, ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_BEQ = 4'b1110, ALU_SRL = 4'b1111;
  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_e;
  typedef enum logic [1:0] {OPA_RS, OPA_RT, OPA_ZERO} opa_e;
  typedef enum logic [1:0] {OPB_RT, OPB_IMM, OPB_ZERO} opb_e;
  typedef struct packed {
    logic [3:0]        alu_ctrl;
    opa_e              opa;
    opb_e              opb;
    logic [DATA_W-1:0] imm;
    logic [5:0]        shamt;
    logic [REG_W-1:0]  rs, rt, rd;
    logic              reg_wen, mem_read, mem_write, branch, use_rs, use_rt, illegal;
  } dec_t;
  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] data1, data2;
    logic [5:0]        shamt;
    logic [REG_W-1:0]  rd;
    logic              reg_wen, mem_read, mem_write, branch;
    logic [DATA_W-1:0] store_data, pc;
  } id_ex_t;
  function automatic fwd_e fwd_sel(input logic [REG_W-1:0] idx, input logic ex_en,
                                   input logic [REG_W-1:0] ex_rd, input logic mem_en,
                                   input logic [REG_W-1:0] mem_rd, input logic wb_en,
                                   input logic [REG_W-1:0] wb_rd);
    return idx == '0 ? FWD_RF : (ex_en && ex_rd == idx) ? FWD_EX :
           (mem_en && mem_rd == idx) ? FWD_MEM : (wb_en && wb_rd == idx) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/id_decoder.sv
// id_decoder: combinational MIPS instruction decode into ALU code, operand selects and control bits.
module id_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [5:0] op, fn;
  logic       zext;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  always_comb begin
    dec         = '0;
    zext        = 1'b0;
    dec.opa     = OPA_RS;
    dec.opb     = OPB_IMM;
    dec.rs      = instr[25:21];
    dec.rt      = instr[20:16];
    dec.rd      = instr[20:16];
    dec.shamt   = {1'b0, instr[10:6]};
    dec.reg_wen = 1'b1;
    dec.use_rs  = 1'b1;
    case (op)
      OP_RTYPE: begin
        dec.rd     = instr[15:11];
        dec.opb    = OPB_RT;
        dec.use_rt = 1'b1;
        case (fn)
          F_ADD, F_ADDU: dec.alu_ctrl = ALU_ADD;
          F_SUB, F_SUBU: dec.alu_ctrl = ALU_SUB;
          F_AND:         dec.alu_ctrl = ALU_AND;
          F_OR:          dec.alu_ctrl = ALU_OR;
          F_XOR:         dec.alu_ctrl = ALU_XOR;
          F_SLT:         dec.alu_ctrl = ALU_SLT;
          F_SLL, F_SRL: begin
            dec.alu_ctrl = fn == F_SLL ? ALU_SLL : ALU_SRL;
            dec.opa      = OPA_RT;
            dec.opb      = OPB_ZERO;
            dec.use_rs   = 1'b0;
          end
          default:       dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: dec.alu_ctrl = ALU_ADD;
      OP_SLTI: dec.alu_ctrl = ALU_SLT;
      OP_ANDI: begin dec.alu_ctrl = ALU_AND; zext = 1'b1; end
      OP_ORI:  begin dec.alu_ctrl = ALU_OR;  zext = 1'b1; end
      OP_XORI: begin dec.alu_ctrl = ALU_XOR; zext = 1'b1; end
      OP_LUI: begin
        dec.alu_ctrl = ALU_LUI;
        zext         = 1'b1;
        dec.opa      = OPA_ZERO;
        dec.use_rs   = 1'b0;
      end
      OP_LW: begin dec.alu_ctrl = ALU_ADD; dec.mem_read = 1'b1; end
      OP_SW: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.mem_write = 1'b1;
        dec.reg_wen   = 1'b0;
        dec.use_rt    = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_ctrl = ALU_BEQ;
        dec.opb      = OPB_RT;
        dec.use_rt   = 1'b1;
        dec.branch   = 1'b1;
        dec.reg_wen  = 1'b0;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = zext ? {{(DATA_W-16){1'b0}}, instr[15:0]} : {{(DATA_W-16){instr[15]}}, instr[15:0]};
    // an illegal encoding reads nothing, so it can never trigger a load-use stall
    if (dec.illegal) {dec.use_rs, dec.use_rt, dec.reg_wen} = '0;
    if (dec.rd == '0) dec.reg_wen = 1'b0;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS decode/issue stage with operand forwarding, load-use stall and the ID/EX register.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN    = DATA_W,
  parameter int RADDR_W = REG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_id_valid,
  input  logic [31:0]        if_id_instr,
  input  logic [XLEN-1:0]    if_id_pc,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic [XLEN-1:0]    ex_alu_res,
  input  logic               ex_mem_wen,
  input  logic [RADDR_W-1:0] ex_mem_rd,
  input  logic [XLEN-1:0]    ex_mem_data,
  input  logic               mem_wb_wen,
  input  logic [RADDR_W-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]    mem_wb_data,
  input  logic               ex_hold,
  input  logic               flush,
  output logic               id_stall,
  output logic               ill_instr,
  output logic               id_ex_valid,
  output logic [3:0]         ex_alu_ctrl,
  output logic [XLEN-1:0]    ex_data1,
  output logic [XLEN-1:0]    ex_data2,
  output logic [5:0]         ex_shamt,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_wen,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [XLEN-1:0]    ex_pc
);
  dec_t            dec;
  id_ex_t          id_ex_d, id_ex_q, issue;
  fwd_e            fwd1, fwd2;
  logic [XLEN-1:0] rs_val, rt_val;
  logic            ex_fwd_en, load_use, ill_d, ill_q;
  id_decoder u_dec (.instr(if_id_instr), .dec(dec));
  assign rf_raddr1 = dec.rs;
  assign rf_raddr2 = dec.rt;
  assign ex_fwd_en = id_ex_q.valid && id_ex_q.reg_wen;
  assign fwd1 = fwd_sel(dec.rs, ex_fwd_en, id_ex_q.rd, ex_mem_wen, ex_mem_rd, mem_wb_wen, mem_wb_rd);
  assign fwd2 = fwd_sel(dec.rt, ex_fwd_en, id_ex_q.rd, ex_mem_wen, ex_mem_rd, mem_wb_wen, mem_wb_rd);
  assign rs_val = fwd1 == FWD_EX ? ex_alu_res : fwd1 == FWD_MEM ? ex_mem_data :
                  fwd1 == FWD_WB ? mem_wb_data : rf_rdata1;
  assign rt_val = fwd2 == FWD_EX ? ex_alu_res : fwd2 == FWD_MEM ? ex_mem_data :
                  fwd2 == FWD_WB ? mem_wb_data : rf_rdata2;
  // a load's data only exists from MEM onward, so its consumer waits one cycle
  assign load_use = if_id_valid && id_ex_q.valid && id_ex_q.mem_read && id_ex_q.rd != '0 &&
                    ((dec.use_rs && id_ex_q.rd == dec.rs) || (dec.use_rt && id_ex_q.rd == dec.rt));
  assign id_stall = ex_hold || (!flush && load_use);
  always_comb begin
    issue            = '0;
    issue.valid      = 1'b1;
    issue.alu_ctrl   = dec.alu_ctrl;
    issue.data1      = dec.opa == OPA_RS ? rs_val : dec.opa == OPA_RT ? rt_val : '0;
    issue.data2      = dec.opb == OPB_RT ? rt_val : dec.opb == OPB_IMM ? dec.imm : '0;
    issue.shamt      = dec.shamt;
    issue.rd         = dec.rd;
    issue.reg_wen    = dec.reg_wen;
    issue.mem_read   = dec.mem_read;
    issue.mem_write  = dec.mem_write;
    issue.branch     = dec.branch;
    issue.store_data = dec.mem_write ? rt_val : '0;
    issue.pc         = if_id_pc;
    id_ex_d = ex_hold ? id_ex_q : (flush || load_use || !if_id_valid || dec.illegal) ? '0 : issue;
    ill_d   = !ex_hold && !flush && !load_use && if_id_valid && dec.illegal;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_ex_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      id_ex_q <= id_ex_d;
      ill_q   <= ill_d;
    end
  assign ill_instr     = ill_q;
  assign id_ex_valid   = id_ex_q.valid;
  assign ex_alu_ctrl   = id_ex_q.alu_ctrl;
  assign ex_data1      = id_ex_q.data1;
  assign ex_data2      = id_ex_q.data2;
  assign ex_shamt      = id_ex_q.shamt;
  assign ex_rd         = id_ex_q.rd;
  assign ex_reg_wen    = id_ex_q.reg_wen;
  assign ex_mem_read   = id_ex_q.mem_read;
  assign ex_mem_write  = id_ex_q.mem_write;
  assign ex_branch     = id_ex_q.branch;
  assign ex_store_data = id_ex_q.store_data;
  assign ex_pc         = id_ex_q.pc;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench; a reference model predicts the ID/EX state every cycle and a monitor compares.
module tb_id_ex_stage;
  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2;
    logic [5:0]  shamt;
    logic [4:0]  rd;
    logic        wen, mrd, mwr, br;
    logic [31:0] sd, pc;
  } st_t;
  typedef struct {
    st_t  st;
    logic ill;
    logic stall;
  } item_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        if_id_valid, ex_mem_wen, mem_wb_wen, ex_hold, flush, id_stall, ill_instr, id_ex_valid;
  logic        ex_reg_wen, ex_mem_read, ex_mem_write, ex_branch;
  logic [31:0] if_id_instr, if_id_pc, rf_rdata1, rf_rdata2, ex_alu_res, ex_mem_data, mem_wb_data;
  logic [31:0] ex_data1, ex_data2, ex_store_data, ex_pc;
  logic [4:0]  rf_raddr1, rf_raddr2, ex_mem_rd, mem_wb_rd, ex_rd;
  logic [3:0]  ex_alu_ctrl;
  logic [5:0]  ex_shamt;
  logic [31:0] rf [32];
  st_t         dut, m_cur;
  logic        m_ill, last_stall, stall_smp;
  item_t       q[$];
  int          checks = 0, errors = 0;
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  assign dut = {id_ex_valid, ex_alu_ctrl, ex_data1, ex_data2, ex_shamt, ex_rd, ex_reg_wen,
                ex_mem_read, ex_mem_write, ex_branch, ex_store_data, ex_pc};

  id_ex_stage dut_i (
    .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .ex_alu_res(ex_alu_res), .ex_mem_wen(ex_mem_wen), .ex_mem_rd(ex_mem_rd),
    .ex_mem_data(ex_mem_data), .mem_wb_wen(mem_wb_wen), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .ex_hold(ex_hold), .flush(flush), .id_stall(id_stall),
    .ill_instr(ill_instr), .id_ex_valid(id_ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_shamt(ex_shamt), .ex_rd(ex_rd),
    .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // most recent producer wins; register 0 always reads the register file
  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return rf[0];
    if (m_cur.valid && m_cur.wen && m_cur.rd == r) return ex_alu_res;
    if (ex_mem_wen && ex_mem_rd == r) return ex_mem_data;
    if (mem_wb_wen && mem_wb_rd == r) return mem_wb_data;
    return rf[r];
  endfunction

  task automatic model(output item_t it, output st_t nxt, output logic ill_n);
    logic [31:0] ins, simm, zimm;
    logic [4:0]  rs, rt;
    logic        ok, urs, urt, nowen, stall;
    int          form;
    st_t         e;
    ins  = if_id_instr;
    rs   = ins[25:21];
    rt   = ins[20:16];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    ok = 1'b1; nowen = 1'b0; form = 2; urs = 1'b0; urt = 1'b0;
    e = '0;
    e.valid = 1'b1; e.shamt = {1'b0, ins[10:6]}; e.pc = if_id_pc; e.rd = rt;
    case (ins[31:26])
      6'h00: begin
        e.rd = ins[15:11]; form = 0;
        case (ins[5:0])
          6'h20, 6'h21: e.ctrl = 4'b0001;
          6'h22, 6'h23: e.ctrl = 4'b0010;
          6'h24: e.ctrl = 4'b0100;
          6'h25: e.ctrl = 4'b0101;
          6'h26: e.ctrl = 4'b0110;
          6'h2A: e.ctrl = 4'b1010;
          6'h00: begin e.ctrl = 4'b0000; form = 1; end
          6'h02: begin e.ctrl = 4'b1111; form = 1; end
          default: ok = 1'b0;
        endcase
      end
      6'h08, 6'h09: e.ctrl = 4'b0001;
      6'h0A: e.ctrl = 4'b1010;
      6'h0C: begin e.ctrl = 4'b0100; form = 3; end
      6'h0D: begin e.ctrl = 4'b0101; form = 3; end
      6'h0E: begin e.ctrl = 4'b0110; form = 3; end
      6'h0F: begin e.ctrl = 4'b0111; form = 4; end
      6'h23: begin e.ctrl = 4'b0001; e.mrd = 1'b1; end
      6'h2B: begin e.ctrl = 4'b0001; e.mwr = 1'b1; nowen = 1'b1; end
      6'h04: begin e.ctrl = 4'b1110; form = 0; e.br = 1'b1; nowen = 1'b1; end
      default: ok = 1'b0;
    endcase
    e.wen = !nowen && e.rd != 5'd0;
    case (form)
      0: begin e.d1 = opnd(rs); e.d2 = opnd(rt); urs = 1'b1; urt = 1'b1; end
      1: begin e.d1 = opnd(rt); e.d2 = 32'h0; urt = 1'b1; end
      2: begin e.d1 = opnd(rs); e.d2 = simm; urs = 1'b1; end
      3: begin e.d1 = opnd(rs); e.d2 = zimm; urs = 1'b1; end
      default: begin e.d1 = 32'h0; e.d2 = zimm; end
    endcase
    if (e.mwr) begin e.sd = opnd(rt); urt = 1'b1; end
    stall = if_id_valid && ok && m_cur.valid && m_cur.mrd && m_cur.rd != 5'd0 &&
            ((urs && rs == m_cur.rd) || (urt && rt == m_cur.rd));
    it.st    = m_cur;
    it.ill   = m_ill;
    it.stall = ex_hold || (!flush && stall);
    nxt   = ex_hold ? m_cur : (flush || stall || !if_id_valid || !ok) ? '0 : e;
    ill_n = !ex_hold && !flush && !stall && if_id_valid && !ok;
  endtask

  task automatic step(input logic [31:0] ins, input logic v, input logic hold, input logic fl);
    item_t it;
    st_t   nxt;
    logic  il;
    if_id_instr = ins; if_id_valid = v; ex_hold = hold; flush = fl; if_id_pc = $urandom;
    model(it, nxt, il);
    q.push_back(it);
    last_stall = it.stall;
    #1 stall_smp = id_stall;
    @(posedge clk); #1;
    m_cur = nxt;
    m_ill = il;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn_tab [10];
    logic [5:0] op_tab [10];
    logic [4:0] a, b, d, sh;
    logic [15:0] im;
    int k;
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02};
    op_tab = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04};
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    sh = 5'($urandom); im = 16'($urandom);
    k = $urandom_range(0, 21);
    if (k < 10) return {6'h00, a, b, d, sh, fn_tab[k]};
    if (k < 20) return {op_tab[k-10], a, b, im};
    return k == 20 ? {6'h00, a, b, d, sh, 6'h3F} : {6'h3E, a, b, im};
  endfunction

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("id_ex_state", dut, it.st);
        chk("ill_instr", ill_instr, it.ill);
        chk("id_stall", id_stall, it.stall);
      end
    end
  end

  initial begin : stim
    logic [31:0] ins, ar;
    logic        v, h, f;
    st_t         old;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    if_id_valid = 0; if_id_instr = 0; if_id_pc = 0; ex_alu_res = 0; ex_hold = 0; flush = 0;
    ex_mem_wen = 0; ex_mem_rd = 0; ex_mem_data = 0; mem_wb_wen = 0; mem_wb_rd = 0; mem_wb_data = 0;
    m_cur = '0; m_ill = 1'b0; last_stall = 1'b0; stall_smp = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {dut, ill_instr, id_stall}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(32'h2001FFFB, 1, 0, 0);
    chk("addi_valid", id_ex_valid, 1); chk("addi_ctrl", ex_alu_ctrl, 4'b0001);
    chk("addi_data1", ex_data1, 0); chk("addi_data2", ex_data2, 32'hFFFFFFFB);
    chk("addi_rd", ex_rd, 1); chk("addi_wen", ex_reg_wen, 1);
    step(32'h34028000, 1, 0, 0);
    chk("ori_data2", ex_data2, 32'h00008000); chk("ori_ctrl", ex_alu_ctrl, 4'b0101);
    rf[4] = 32'h1;
    step({6'h00, 5'd0, 5'd4, 5'd3, 5'd31, 6'h00}, 1, 0, 0);
    chk("sll_ctrl", ex_alu_ctrl, 4'b0000); chk("sll_data1", ex_data1, 32'h1);
    chk("sll_shamt", ex_shamt, 6'd31);
    ex_alu_res = 32'h11; ex_mem_wen = 1; ex_mem_rd = 3; ex_mem_data = 32'h22;
    mem_wb_wen = 1; mem_wb_rd = 3; mem_wb_data = 32'h33;
    step({6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20}, 1, 0, 0);
    chk("fwd_prio_data1", ex_data1, 32'h11); chk("fwd_prio_data2", ex_data2, 32'h11);
    ex_mem_wen = 0; mem_wb_wen = 0;
    step({6'h23, 5'd0, 5'd5, 16'h0}, 1, 0, 0);
    step({6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20}, 1, 0, 0);
    chk("loaduse_stall", stall_smp, 1); chk("loaduse_bubble", id_ex_valid, 0);
    ex_alu_res = 32'h77; ex_mem_wen = 1; ex_mem_rd = 5; ex_mem_data = 32'hDEADBEEF;
    step({6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20}, 1, 0, 0);
    chk("loaduse_release", stall_smp, 0); chk("loaduse_fwd", ex_data1, 32'hDEADBEEF);
    ex_mem_wen = 0;
    step(32'h20070001, 1, 1, 1);
    chk("hold_flush_stall", stall_smp, 1);
    chk("hold_flush_keep", {id_ex_valid, ex_rd, ex_data1}, {1'b1, 5'd6, 32'hDEADBEEF});
    step(32'h20070001, 1, 0, 1);
    chk("flush_stall", stall_smp, 0);
    chk("flush_bubble", {id_ex_valid, ex_alu_ctrl, ex_data1}, '0);
    step(32'hFC000000, 1, 0, 0);
    chk("illegal_pulse", {ill_instr, id_ex_valid}, 2'b10);
    step(32'h0, 0, 0, 0);
    chk("illegal_one_cycle", ill_instr, 0);
    step(32'h2001FFFB, 1, 0, 0);
    if_id_valid = 0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {dut, ill_instr, id_stall}, '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    m_cur = '0; m_ill = 1'b0; last_stall = 1'b0;
    v = 0; ins = 0;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        ins = rand_instr();
        v = $urandom_range(0, 9) != 0;
      end
      h = $urandom_range(0, 9) == 0;
      f = !h && $urandom_range(0, 11) == 0;
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      ex_alu_res = $urandom;
      ar = ex_alu_res;
      old = m_cur;
      step(ins, v, h, f);
      if (!h) begin
        mem_wb_wen = ex_mem_wen; mem_wb_rd = ex_mem_rd; mem_wb_data = ex_mem_data;
        ex_mem_wen = old.valid && old.wen; ex_mem_rd = old.rd;
        ex_mem_data = old.mrd ? $urandom : ar;
      end
      if ($urandom_range(0, 7) == 0) begin
        ex_mem_wen = 1; ex_mem_rd = 0; ex_mem_data = $urandom;
      end
    end
    step(32'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
